// File: rtl/digit_pulse_sequencer_if.sv
// Control and timing bundle of the digit pulse sequencer: run/step in,
// one-hot digit pulses, counters and cycle markers out.
interface digit_pulse_sequencer_if #(
  parameter int DIGITS       = 36,
  parameter int MINOR_CYCLES = 16
);
  localparam int DW = $clog2(DIGITS);
  localparam int MW = (MINOR_CYCLES > 1) ? $clog2(MINOR_CYCLES) : 1;

  // run is a level (continue at each minor-cycle end); step is sampled only
  // while idle and starts one minor cycle. Neither input has a ready: a step
  // seen while busy is dropped, and run is only looked at on minor-cycle ends.
  logic              run;
  logic              step;
  logic [DIGITS-1:0] digit_pulse;
  logic [DW-1:0]     digit_index;
  logic [MW-1:0]     minor_cycle;
  logic              minor_start;
  logic              major_start;
  logic              busy;
  logic [1:0]        seq_state;

  modport master (
    input  run, step,
    output digit_pulse, digit_index, minor_cycle, minor_start, major_start,
           busy, seq_state
  );

  modport slave (
    output run, step,
    input  digit_pulse, digit_index, minor_cycle, minor_start, major_start,
           busy, seq_state
  );
endinterface

// File: rtl/digit_pulse_sequencer.sv
// Registered one-hot digit pulse generator for a DIGITS-long minor cycle,
// counting minor cycles within a major cycle, with run/halt and single-step.
module digit_pulse_sequencer #(
  parameter int DIGITS       = 36,
  parameter int MINOR_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst,
  digit_pulse_sequencer_if.master bus
);
  localparam int DW = $clog2(DIGITS);
  localparam int MW = (MINOR_CYCLES > 1) ? $clog2(MINOR_CYCLES) : 1;

  localparam logic [DIGITS-1:0] FIRST_PULSE = DIGITS'(1);
  localparam logic [DW-1:0]     LAST_INDEX  = DW'(DIGITS - 1);
  localparam logic [MW-1:0]     LAST_MINOR  = MW'(MINOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIGITS-1:0] pulse_q, pulse_d;
  logic [DW-1:0]     index_q, index_d;
  logic [MW-1:0]     minor_q, minor_d;
  logic [MW-1:0]     minor_inc;
  logic              mstart_q, mstart_d;
  logic              jstart_q, jstart_d;
  logic              busy_q, busy_d;
  logic              last_digit;

  assign last_digit = (index_q == LAST_INDEX);
  assign minor_inc  = (minor_q == LAST_MINOR) ? '0 : minor_q + MW'(1);

  // Every output is computed here one clock ahead and then registered, so the
  // pulses seen downstream come straight from flops and cannot glitch.
  always_comb begin
    state_d  = state_q;
    pulse_d  = '0;
    index_d  = '0;
    minor_d  = minor_q;
    mstart_d = 1'b0;
    jstart_d = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.run || bus.step) begin
          state_d  = bus.run ? RUN : STEP;
          pulse_d  = FIRST_PULSE;
          busy_d   = 1'b1;
          mstart_d = 1'b1;
          jstart_d = (minor_q == '0);
        end
      end
      RUN, STEP: begin
        if (last_digit) begin
          minor_d = minor_inc;
          // A step cycle that finds run high carries on exactly like RUN.
          if (bus.run) begin
            state_d  = RUN;
            pulse_d  = FIRST_PULSE;
            busy_d   = 1'b1;
            mstart_d = 1'b1;
            jstart_d = (minor_inc == '0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          pulse_d = pulse_q << 1;
          index_d = index_q + DW'(1);
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pulse_q  <= '0;
      index_q  <= '0;
      minor_q  <= '0;
      mstart_q <= 1'b0;
      jstart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      index_q  <= index_d;
      minor_q  <= minor_d;
      mstart_q <= mstart_d;
      jstart_q <= jstart_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.digit_pulse = pulse_q;
  assign bus.digit_index = index_q;
  assign bus.minor_cycle = minor_q;
  assign bus.minor_start = mstart_q;
  assign bus.major_start = jstart_q;
  assign bus.busy        = busy_q;
  assign bus.seq_state   = state_q;
endmodule

// File: tb/tb_digit_pulse_sequencer.sv
// Bench for digit_pulse_sequencer: a 36x16 instance and a 17x4 instance,
// each checked every cycle against an abstract position/minor-count model.
module tb_digit_pulse_sequencer;
  localparam int DA = 36;
  localparam int MA = 16;
  localparam int DB = 17;
  localparam int MB = 4;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  digit_pulse_sequencer_if #(.DIGITS(DA), .MINOR_CYCLES(MA)) bus_a ();
  digit_pulse_sequencer_if #(.DIGITS(DB), .MINOR_CYCLES(MB)) bus_b ();

  digit_pulse_sequencer #(.DIGITS(DA), .MINOR_CYCLES(MA)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a.master)
  );

  digit_pulse_sequencer #(.DIGITS(DB), .MINOR_CYCLES(MB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b.master)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  // A sequencer is either idle or sitting at digit position pos; a minor cycle
  // ends at pos == D-1 and continues only if run is high at that moment.
  bit act_a, act_b;
  int pos_a, pos_b;
  int min_a, min_b;

  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      act_a <= 1'b0; pos_a <= 0; min_a <= 0;
    end else if (!act_a) begin
      if (bus_a.run || bus_a.step) begin act_a <= 1'b1; pos_a <= 0; end
    end else if (pos_a == DA - 1) begin
      min_a <= (min_a + 1) % MA; act_a <= bus_a.run; pos_a <= 0;
    end else begin
      pos_a <= pos_a + 1;
    end
  end

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      act_b <= 1'b0; pos_b <= 0; min_b <= 0;
    end else if (!act_b) begin
      if (bus_b.run || bus_b.step) begin act_b <= 1'b1; pos_b <= 0; end
    end else if (pos_b == DB - 1) begin
      min_b <= (min_b + 1) % MB; act_b <= bus_b.run; pos_b <= 0;
    end else begin
      pos_b <= pos_b + 1;
    end
  end

  function automatic logic [63:0] onehot(input int p);
    logic [63:0] one;
    one = 64'd1;
    return one << p;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    check("a_pulse", 64'(bus_a.digit_pulse), act_a ? onehot(pos_a) : 64'd0);
    check("a_index", 64'(bus_a.digit_index), act_a ? 64'(pos_a) : 64'd0);
    check("a_minor", 64'(bus_a.minor_cycle), 64'(min_a));
    check("a_mstart", 64'(bus_a.minor_start), 64'(act_a && pos_a == 0));
    check("a_jstart", 64'(bus_a.major_start), 64'(act_a && pos_a == 0 && min_a == 0));
    check("a_busy", 64'(bus_a.busy), 64'(act_a));
    check("b_pulse", 64'(bus_b.digit_pulse), act_b ? onehot(pos_b) : 64'd0);
    check("b_index", 64'(bus_b.digit_index), act_b ? 64'(pos_b) : 64'd0);
    check("b_minor", 64'(bus_b.minor_cycle), 64'(min_b));
    check("b_mstart", 64'(bus_b.minor_start), 64'(act_b && pos_b == 0));
    check("b_jstart", 64'(bus_b.major_start), 64'(act_b && pos_b == 0 && min_b == 0));
    check("b_busy", 64'(bus_b.busy), 64'(act_b));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle_a(input int lim);
    int n;
    n = 0;
    while (bus_a.busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("a_idle_timeout", 64'(bus_a.busy), 64'd0);
  endtask

  task automatic wait_idle_b(input int lim);
    int n;
    n = 0;
    while (bus_b.busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("b_idle_timeout", 64'(bus_b.busy), 64'd0);
  endtask

  // ---------------- directed stimulus ----------------
  int majors;
  int busy_cnt;
  int pulse_cnt;
  int major_pos[$];

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.run = 1'b0; bus_a.step = 1'b0;
    bus_b.run = 1'b0; bus_b.step = 1'b0;

    // 1: reset state and quiet idle
    #1;
    check("t1_rst_pulse", 64'(bus_a.digit_pulse), 64'd0);
    check("t1_rst_state", 64'(bus_a.seq_state), 64'd0);
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_busy", 64'(bus_a.busy), 64'd0);
    check("t1_pulse", 64'(bus_a.digit_pulse), 64'd0);
    check("t1_minor", 64'(bus_a.minor_cycle), 64'd0);

    // 2: three back-to-back minor cycles
    bus_a.run = 1'b1;
    majors = 0;
    for (int i = 0; i < 3 * DA; i++) begin
      @(negedge clk);
      check("t2_pulse", 64'(bus_a.digit_pulse), onehot(i % DA));
      check("t2_minor", 64'(bus_a.minor_cycle), 64'(i / DA));
      if (bus_a.major_start) majors++;
    end
    check("t2_major_count", 64'(majors), 64'd1);

    // 3: drop run at digit 10, cycle still completes
    repeat (11) @(negedge clk);
    check("t3_index_drop", 64'(bus_a.digit_index), 64'd10);
    check("t3_minor_drop", 64'(bus_a.minor_cycle), 64'd3);
    bus_a.run = 1'b0;
    repeat (25) @(negedge clk);
    check("t3_last_digit", 64'(bus_a.digit_pulse), onehot(35));
    @(negedge clk);
    check("t3_idle_busy", 64'(bus_a.busy), 64'd0);
    check("t3_idle_minor", 64'(bus_a.minor_cycle), 64'd4);
    repeat (3) @(negedge clk);
    bus_a.run = 1'b1;
    @(negedge clk);
    check("t3_resume_pulse", 64'(bus_a.digit_pulse), 64'd1);
    check("t3_resume_minor", 64'(bus_a.minor_cycle), 64'd4);
    check("t3_resume_major", 64'(bus_a.major_start), 64'd0);
    bus_a.run = 1'b0;
    wait_idle_a(40);
    check("t3_end_minor", 64'(bus_a.minor_cycle), 64'd5);

    // 4: single step, with a second step during busy ignored
    bus_a.step = 1'b1;
    @(negedge clk);
    bus_a.step = 1'b0;
    busy_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus_a.busy) busy_cnt++;
      if (bus_a.digit_pulse != '0) pulse_cnt++;
      if (i == 5) bus_a.step = 1'b1;
      if (i == 6) bus_a.step = 1'b0;
      @(negedge clk);
    end
    check("t4_busy_cycles", 64'(busy_cnt), 64'd36);
    check("t4_pulses", 64'(pulse_cnt), 64'd36);
    check("t4_minor", 64'(bus_a.minor_cycle), 64'd6);

    // 5: full major cycle wrap from a fresh reset
    rst_a = 1'b1;
    #1;
    check("t5_rst_minor", 64'(bus_a.minor_cycle), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    bus_a.run = 1'b1;
    major_pos.delete();
    for (int i = 0; i < MA * DA + 5; i++) begin
      @(negedge clk);
      if (bus_a.major_start) major_pos.push_back(i);
      if (i == 575) check("t5_minor_15", 64'(bus_a.minor_cycle), 64'd15);
      if (i == 576) check("t5_minor_wrap", 64'(bus_a.minor_cycle), 64'd0);
    end
    check("t5_major_n", 64'(major_pos.size()), 64'd2);
    if (major_pos.size() == 2) begin
      check("t5_major_0", 64'(major_pos[0]), 64'd0);
      check("t5_major_1", 64'(major_pos[1]), 64'd576);
    end
    bus_a.run = 1'b0;
    wait_idle_a(40);

    // 6: DIGITS=17, MINOR_CYCLES=4; run+step together, reset mid-cycle
    bus_b.run = 1'b1;
    bus_b.step = 1'b1;
    @(negedge clk);
    bus_b.step = 1'b0;
    check("t6_first", 64'(bus_b.digit_pulse), 64'd1);
    repeat (DB + 8) @(negedge clk);
    check("t6_index_8", 64'(bus_b.digit_index), 64'd8);
    check("t6_minor_1", 64'(bus_b.minor_cycle), 64'd1);
    rst_b = 1'b1;
    bus_b.run = 1'b0;
    #1;
    check("t6_rst_pulse", 64'(bus_b.digit_pulse), 64'd0);
    check("t6_rst_index", 64'(bus_b.digit_index), 64'd0);
    check("t6_rst_minor", 64'(bus_b.minor_cycle), 64'd0);
    check("t6_rst_busy", 64'(bus_b.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    bus_b.run = 1'b1;
    major_pos.delete();
    for (int i = 0; i < MB * DB + 3; i++) begin
      @(negedge clk);
      check("t6_pulse", 64'(bus_b.digit_pulse), onehot(i % DB));
      check("t6_minor", 64'(bus_b.minor_cycle), 64'((i / DB) % MB));
      if (bus_b.major_start) major_pos.push_back(i);
    end
    check("t6_major_n", 64'(major_pos.size()), 64'd2);
    if (major_pos.size() == 2) check("t6_major_1", 64'(major_pos[1]), 64'd68);
    bus_b.run = 1'b0;
    wait_idle_b(30);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
